balance_db_arbiter: RTL and testbench

Shares the single-port account balance memory among NUM_REQ ATM front-ends, which are requesters 0..NUM_REQ-1.
A round-robin arbiter grants one requester at a time. It then runs an atomic read-modify-write (balance query, withdraw or deposit) and returns the resulting balance and a success flag to the granted requester.
It sits between the per-terminal ATM controllers and the balance memory. It replaces direct, unarbitrated database access.

---
 rtl/balance_db_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_balance_db_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/balance_db_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : balance_db_arbiter
// Description : Round-robin arbiter running atomic balance read-modify-write
//               transactions on a single-port account memory.
// Revision    : 1.0 - initial release
// ============================================================================
module balance_db_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_ACC = 10,
  parameter int BAL_W   = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [2*NUM_REQ-1:0]     op,
  input  logic [4*NUM_REQ-1:0]     acc_idx,
  input  logic [BAL_W*NUM_REQ-1:0] amount,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [BAL_W-1:0]         result_balance,
  output logic                     result_success,
  output logic                     busy,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [3:0]               mem_addr,
  output logic [BAL_W-1:0]         mem_wdata,
  input  logic [BAL_W-1:0]         mem_rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RD   = 2'd1;
  localparam logic [1:0] c_ST_EXEC = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  localparam logic [1:0] c_OP_BAL = 2'd0;
  localparam logic [1:0] c_OP_WD  = 2'd1;
  localparam logic [1:0] c_OP_DEP = 2'd2;
  localparam logic [1:0] c_OP_RSV = 2'd3;

  localparam logic [4:0]    c_NUM_ACC  = 5'(NUM_ACC);
  localparam logic [IW-1:0] c_LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [IW:0]   c_NREQ_W   = (IW+1)'(NUM_REQ);

  logic [1:0]         r_state;
  logic [IW-1:0]      r_last;
  logic [NUM_REQ-1:0] r_grant;
  logic [1:0]         r_op;
  logic [3:0]         r_acc;
  logic [BAL_W-1:0]   r_amt;
  logic [BAL_W-1:0]   r_res_bal;
  logic               r_res_ok;

  logic               w_found;
  logic [IW-1:0]      w_sel;
  logic [IW:0]        w_cand;
  logic [1:0]         w_sel_op;
  logic [3:0]         w_sel_acc;
  logic [BAL_W-1:0]   w_sel_amt;
  logic [NUM_REQ-1:0] w_onehot;
  logic [BAL_W:0]     w_sum;
  logic [BAL_W-1:0]   w_exec_bal;
  logic               w_exec_ok;
  logic               w_exec_wr;
  logic               w_acc_ok;

  // Circular search starting just after the last owner.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, r_last} + (IW+1)'(k);
      if (w_cand >= c_NREQ_W) w_cand = w_cand - c_NREQ_W;
      if (!w_found && req[w_cand[IW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[IW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_op  = '0;
    w_sel_acc = '0;
    w_sel_amt = '0;
    w_onehot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == IW'(i)) begin
        w_sel_op    = op[2*i +: 2];
        w_sel_acc   = acc_idx[4*i +: 4];
        w_sel_amt   = amount[BAL_W*i +: BAL_W];
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_sum    = {1'b0, mem_rdata} + {1'b0, r_amt};
  assign w_acc_ok = ({1'b0, r_acc} < c_NUM_ACC) && (r_op != c_OP_RSV);

  // Failed operations report the unchanged balance read from memory.
  always_comb begin
    w_exec_bal = mem_rdata;
    w_exec_ok  = 1'b0;
    w_exec_wr  = 1'b0;
    case (r_op)
      c_OP_BAL: w_exec_ok = 1'b1;
      c_OP_WD: begin
        if (r_amt <= mem_rdata) begin
          w_exec_bal = mem_rdata - r_amt;
          w_exec_ok  = 1'b1;
          w_exec_wr  = 1'b1;
        end
      end
      c_OP_DEP: begin
        if (!w_sum[BAL_W]) begin
          w_exec_bal = w_sum[BAL_W-1:0];
          w_exec_ok  = 1'b1;
          w_exec_wr  = 1'b1;
        end
      end
      default: w_exec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_last    <= c_LAST_RST;
      r_grant   <= '0;
      r_op      <= '0;
      r_acc     <= '0;
      r_amt     <= '0;
      r_res_bal <= '0;
      r_res_ok  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_found) begin
            r_op    <= w_sel_op;
            r_acc   <= w_sel_acc;
            r_amt   <= w_sel_amt;
            r_grant <= w_onehot;
            r_last  <= w_sel;
            r_state <= c_ST_RD;
          end
        end
        c_ST_RD: begin
          if (w_acc_ok) begin
            r_state <= c_ST_EXEC;
          end else begin
            r_res_bal <= '0;
            r_res_ok  <= 1'b0;
            r_state   <= c_ST_DONE;
          end
        end
        c_ST_EXEC: begin
          r_res_bal <= w_exec_bal;
          r_res_ok  <= w_exec_ok;
          r_state   <= c_ST_DONE;
        end
        default: begin
          r_grant <= '0;
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Strobes are gated by rst so an aborted transaction never touches memory.
  assign mem_re         = (r_state == c_ST_RD) && w_acc_ok && !rst;
  assign mem_we         = (r_state == c_ST_EXEC) && w_exec_wr && !rst;
  assign mem_addr       = ((r_state == c_ST_RD) || (r_state == c_ST_EXEC)) ? r_acc : 4'd0;
  assign mem_wdata      = mem_we ? w_exec_bal : '0;
  assign done           = ((r_state == c_ST_DONE) && !rst) ? r_grant : '0;
  assign grant          = r_grant;
  assign busy           = (r_state != c_ST_IDLE);
  assign result_balance = r_res_bal;
  assign result_success = r_res_ok;

endmodule
`default_nettype wire

// File: tb/tb_balance_db_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_balance_db_arbiter
// Description : Scoreboard bench for balance_db_arbiter with a memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_balance_db_arbiter;
  localparam int NUM_REQ = 4;
  localparam int NUM_ACC = 10;
  localparam int BAL_W   = 14;
  localparam int MAXB    = (1 << BAL_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [2*NUM_REQ-1:0]     op;
  logic [4*NUM_REQ-1:0]     acc_idx;
  logic [BAL_W*NUM_REQ-1:0] amount;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [BAL_W-1:0]         result_balance;
  logic                     result_success;
  logic                     busy;
  logic                     mem_re;
  logic                     mem_we;
  logic [3:0]               mem_addr;
  logic [BAL_W-1:0]         mem_wdata;
  logic [BAL_W-1:0]         mem_rdata;

  always #5 clk = ~clk;

  balance_db_arbiter #(.NUM_REQ(NUM_REQ), .NUM_ACC(NUM_ACC), .BAL_W(BAL_W)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .acc_idx(acc_idx), .amount(amount),
    .grant(grant), .done(done), .result_balance(result_balance),
    .result_success(result_success), .busy(busy), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Balance memory with one-cycle read latency and a bench back door.
  logic [BAL_W-1:0] mem [16];
  logic             bd_we;
  logic [3:0]       bd_addr;
  logic [BAL_W-1:0] bd_data;
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int owner; int bal; int ok; } exp_t;
  typedef struct { int addr; int data; } wr_t;
  exp_t sbq[$];
  wr_t  wq[$];
  int   ref_bal[16];
  int   exp_re = 0;
  int   re_cnt = 0;
  int   m_last;

  int t_op[NUM_REQ], t_acc[NUM_REQ], t_amt[NUM_REQ], rem[NUM_REQ];

  // Monitor: every write strobe and done pulse is checked against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_re) re_cnt++;
      if (mem_we) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", mem_wdata, w.data);
        end
      end
      if (done != '0) begin
        if (sbq.size() == 0) chk("unexpected_done", done, 0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_owner", done, 1 << e.owner);
          chk("grant_at_done", grant, 1 << e.owner);
          chk("result_balance", result_balance, e.bal);
          chk("result_success", result_success, e.ok);
        end
      end
    end
  end

  // Transaction-level reference: the account ledger as plain integers.
  task automatic model_txn(input int who);
    exp_t e;
    wr_t  w;
    int   o, a, m, b;
    o = t_op[who]; a = t_acc[who]; m = t_amt[who];
    e.owner = who; e.bal = 0; e.ok = 0;
    if (a < NUM_ACC && o != 3) begin
      exp_re++;
      b = ref_bal[a];
      e.bal = b;
      if (o == 0) e.ok = 1;
      else if (o == 1 && m <= b) begin e.bal = b - m; e.ok = 1; end
      else if (o == 2 && b + m <= MAXB) begin e.bal = b + m; e.ok = 1; end
      if (e.ok == 1 && o != 0) begin
        ref_bal[a] = e.bal;
        w.addr = a; w.data = e.bal;
        wq.push_back(w);
      end
    end
    sbq.push_back(e);
  endtask

  // Predicts service order, then drives requests until every one completes.
  task automatic run_batch(output int lat);
    int mrem[NUM_REQ];
    int left, n, who, issue_c, budget;
    bit found;
    lat = -1; left = 0;
    for (int i = 0; i < NUM_REQ; i++) begin mrem[i] = rem[i]; left += rem[i]; end
    n = left;
    while (left > 0) begin
      found = 0; who = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!found && mrem[(m_last + k) % NUM_REQ] > 0) begin
          found = 1; who = (m_last + k) % NUM_REQ;
        end
      end
      model_txn(who);
      mrem[who]--; left--; m_last = who;
    end
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      op[2*i +: 2]            = 2'(t_op[i]);
      acc_idx[4*i +: 4]       = 4'(t_acc[i]);
      amount[BAL_W*i +: BAL_W] = BAL_W'(t_amt[i]);
      req[i]                  = (rem[i] > 0);
    end
    issue_c = cyc;
    budget  = 10 * n + 10;
    left    = n;
    while (left > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done[i]) begin
          if (lat < 0) lat = cyc - issue_c;
          if (rem[i] > 0) rem[i]--;
          if (rem[i] == 0) req[i] = 1'b0;
          left--;
        end
      end
    end
    if (left > 0) begin
      chk("batch_timeout", left, 0);
      req = '0;
      for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
    end
  endtask

  task automatic single(input int who, input int o, input int a, input int m, output int lat);
    t_op[who] = o; t_acc[who] = a; t_amt[who] = m; rem[who] = 1;
    run_batch(lat);
  endtask

  task automatic bd_write(input int a, input int d);
    bd_we = 1'b1; bd_addr = 4'(a); bd_data = BAL_W'(d);
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_bal[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0;
    m_last = NUM_REQ - 1;
  endtask

  initial begin
    int lat, re_before, sel;
    rst = 1'b1; req = '0; op = '0; acc_idx = '0; amount = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    m_last = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) begin t_op[i] = 0; t_acc[i] = 0; t_amt[i] = 0; rem[i] = 0; end
    for (int a = 0; a < 16; a++) bd_write(a, (a < NUM_ACC) ? int'($urandom_range(0, 12000)) : 0);
    bd_write(3, 500); bd_write(2, 1000); bd_write(5, 16000); bd_write(7, 0);

    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_result_balance", result_balance, 0);
    chk("rst_result_success", result_success, 0);
    rst = 1'b0;

    single(0, 0, 3, 0, lat);
    chk("balance_latency", lat, 3);
    single(1, 1, 2, 300, lat);
    chk("withdraw_latency", lat, 3);
    single(1, 1, 2, 800, lat);
    repeat (3) @(negedge clk);
    chk("hold_result_balance", result_balance, 700);
    chk("hold_result_success", result_success, 0);
    single(2, 2, 5, 383, lat);
    single(2, 2, 5, 1, lat);

    re_before = re_cnt;
    single(3, 0, 12, 0, lat);
    chk("bad_acc_latency", lat, 2);
    single(0, 3, 1, 5, lat);
    chk("bad_op_latency", lat, 2);
    chk("invalid_no_read", re_cnt, re_before);

    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin t_op[i] = 2; t_acc[i] = 7; t_amt[i] = 10; rem[i] = 1; end
    run_batch(lat);
    repeat (2) @(negedge clk);
    chk("acc7_total", mem[7], 40);
    for (int i = 0; i < NUM_REQ; i++) begin t_op[i] = 0; rem[i] = (i == 0) ? 2 : 1; end
    run_batch(lat);

    // Abort a withdraw in its execute cycle.
    @(negedge clk);
    op[3:2] = 2'd1; acc_idx[7:4] = 4'd2; amount[2*BAL_W-1:BAL_W] = BAL_W'(100); req[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1; req = '0;
    exp_re++;
    #1;
    chk("abort_we_forced", mem_we, 0);
    chk("abort_no_done", done, 0);
    @(posedge clk);
    #1;
    chk("abort_grant", grant, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result_balance", result_balance, 0);
    rst = 1'b0;
    m_last = NUM_REQ - 1;
    chk("abort_mem_kept", mem[2], ref_bal[2]);
    t_op[0] = 0; t_acc[0] = 2; rem[0] = 1;
    t_op[2] = 0; t_acc[2] = 5; rem[2] = 1;
    run_batch(lat);

    for (int b = 0; b < 40; b++) begin
      sel = $urandom_range(1, (1 << NUM_REQ) - 1);
      for (int i = 0; i < NUM_REQ; i++) begin
        int r;
        r = $urandom_range(0, 9);
        t_op[i]  = (r < 2) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
        t_acc[i] = $urandom_range(0, 11);
        t_amt[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXB)) : int'($urandom_range(0, 1500));
        rem[i]   = sel[i] ? int'($urandom_range(1, 2)) : 0;
      end
      run_batch(lat);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("writes_drained", wq.size(), 0);
    chk("read_count", re_cnt, exp_re);
    for (int a = 0; a < NUM_ACC; a++) chk("final_ledger", mem[a], ref_bal[a]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
